// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the pipeline sequencer: FSM state encodings
// (also exported on state_o for debug) and the redirect-address idle value.
package pipe_ctrl_pkg;

  // Encoding 2'd3 is deliberately unused; the FSM treats it as illegal.
  typedef enum logic [1:0] {
    PIPE_RUN   = 2'd0,
    PIPE_FLUSH = 2'd1,
    PIPE_WAIT  = 2'd2
  } pipe_state_t;

  // jump_addr_o rests at this value whenever no redirect is issued.
  localparam logic [31:0] ZERO_ADDR = 32'h0000_0000;

endpackage

// File: rtl/pipe_wait_timer.sv
// pipe_wait_timer
// Counts busy-wait cycles of the multi-cycle execute unit and raises a
// sticky timeout once the count reaches MAX_WAIT.
// Ports:
//   clk     in  core clock
//   rst     in  synchronous active-high reset (clears count and timeout)
//   start   in  first busy cycle seen in RUN: count loads 1
//   active  in  busy cycle while waiting: count increments, saturating
//   timeout out sticky flag, cleared only by rst
// Any cycle with neither start nor active clears the count.
module pipe_wait_timer #(
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic active,
  output logic timeout
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

  logic [7:0] wait_cnt;

  // Saturating wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 8'd0;
      timeout  <= 1'b0;
    end else if (start) begin
      wait_cnt <= 8'd1;
      timeout  <= timeout;
    end else if (active) begin
      if (wait_cnt < MAX_CNT) begin
        wait_cnt <= wait_cnt + 8'd1;
        // Raise the flag on the same edge the count lands on MAX_WAIT.
        timeout  <= timeout | ((wait_cnt + 8'd1) == MAX_CNT);
      end else begin
        wait_cnt <= wait_cnt;
        timeout  <= timeout;
      end
    end else begin
      wait_cnt <= 8'd0;
      timeout  <= timeout;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
// Central sequencer for the 5-stage pipeline. Arbitrates redirect, load-use
// and execute-busy requests (jump > busy > load-use) and drives the PC hold,
// the IF/ID and ID/EX bubble holds and the redirect to ifetch.
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   jump_en_i / jump_addr_i  redirect request and target from EX
//   load_use_i               load-use hazard detected in ID
//   ex_busy_i                multi-cycle EX unit still working
//   jump_en_o / jump_addr_o  redirect to ifetch (address 0 when idle)
//   pc_hold_o                freeze PC
//   if_id_hold_o             IF/ID loads NOP
//   id_ex_hold_o             ID/EX loads bubble
//   timeout_o                sticky busy-wait timeout
//   state_o                  current FSM state (debug)
// Hold/jump outputs are combinational from state and inputs, and every
// output is forced to 0 while rst is high.
// Optional: define PIPE_CTRL_PERF_CNT_EN to add stall_cnt_o / flush_cnt_o.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MAX_WAIT     = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        load_use_i,
  input  logic        ex_busy_i,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        pc_hold_o,
  output logic        if_id_hold_o,
  output logic        id_ex_hold_o,
  output logic        timeout_o,
`ifdef PIPE_CTRL_PERF_CNT_EN
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
`endif
  output logic [1:0]  state_o
);

  // A single-cycle flush needs no FLUSH state at all.
  localparam logic       MULTI_FLUSH  = (FLUSH_CYCLES > 1);
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  pipe_state_t state;
  logic [3:0]  flush_cnt;
  logic        dec_jump;
  logic        dec_pc;
  logic        dec_if_id;
  logic        dec_id_ex;
  logic        timer_start;
  logic        timer_active;
  logic        timeout;

  // Hold/redirect decode from the current state and request inputs.
  always_comb begin
    dec_jump     = 1'b0;
    dec_pc       = 1'b0;
    dec_if_id    = 1'b0;
    dec_id_ex    = 1'b0;
    timer_start  = 1'b0;
    timer_active = 1'b0;
    case (state)
      PIPE_RUN: begin
        if (jump_en_i) begin
          dec_jump  = 1'b1;
          dec_if_id = 1'b1;
          dec_id_ex = 1'b1;
        end else if (ex_busy_i) begin
          dec_pc      = 1'b1;
          dec_if_id   = 1'b1;
          dec_id_ex   = 1'b1;
          timer_start = 1'b1;
        end else if (load_use_i) begin
          // Held PC refetches the same instruction, so IF/ID keeps it.
          dec_pc    = 1'b1;
          dec_id_ex = 1'b1;
        end else begin
          dec_jump = 1'b0;
        end
      end
      PIPE_FLUSH: begin
        // Bubbles carry no hazard; only a fresh redirect matters here.
        dec_if_id = 1'b1;
        dec_id_ex = 1'b1;
        if (jump_en_i) begin
          dec_jump = 1'b1;
        end else begin
          dec_jump = 1'b0;
        end
      end
      PIPE_WAIT: begin
        if (ex_busy_i) begin
          // A busy EX cannot resolve a branch, so jump_en_i is ignored.
          dec_pc       = 1'b1;
          dec_if_id    = 1'b1;
          dec_id_ex    = 1'b1;
          timer_active = 1'b1;
        end else if (jump_en_i) begin
          dec_jump  = 1'b1;
          dec_if_id = 1'b1;
          dec_id_ex = 1'b1;
        end else begin
          dec_jump = 1'b0;
        end
      end
      default: begin
        dec_jump = 1'b0;
      end
    endcase
  end

  // FSM state and flush countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PIPE_RUN;
      flush_cnt <= 4'd0;
    end else if (dec_jump) begin
      if (MULTI_FLUSH) begin
        state     <= PIPE_FLUSH;
        flush_cnt <= FLUSH_RELOAD;
      end else begin
        state     <= PIPE_RUN;
        flush_cnt <= 4'd0;
      end
    end else begin
      case (state)
        PIPE_RUN: begin
          state     <= ex_busy_i ? PIPE_WAIT : PIPE_RUN;
          flush_cnt <= 4'd0;
        end
        PIPE_FLUSH: begin
          if (flush_cnt <= 4'd1) begin
            state     <= PIPE_RUN;
            flush_cnt <= 4'd0;
          end else begin
            state     <= PIPE_FLUSH;
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        PIPE_WAIT: begin
          state     <= ex_busy_i ? PIPE_WAIT : PIPE_RUN;
          flush_cnt <= 4'd0;
        end
        default: begin
          state     <= PIPE_RUN;
          flush_cnt <= 4'd0;
        end
      endcase
    end
  end

  pipe_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (timer_start),
    .active  (timer_active),
    .timeout (timeout)
  );

  assign jump_en_o    = ~rst & dec_jump;
  assign jump_addr_o  = (~rst & dec_jump) ? jump_addr_i : ZERO_ADDR;
  assign pc_hold_o    = ~rst & dec_pc;
  assign if_id_hold_o = ~rst & dec_if_id;
  assign id_ex_hold_o = ~rst & dec_id_ex;
  assign timeout_o    = ~rst & timeout;
  assign state_o      = rst ? 2'd0 : state;

`ifdef PIPE_CTRL_PERF_CNT_EN
  // Stall and flush cycle counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= 32'd0;
      flush_cnt_o <= 32'd0;
    end else begin
      stall_cnt_o <= stall_cnt_o + {31'd0, dec_pc & ~dec_jump};
      flush_cnt_o <= flush_cnt_o + {31'd0, dec_if_id & ~dec_pc};
    end
  end
`endif

endmodule
